mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access unit for the pipelined CPU. It consumes the EX/MEM pipeline register outputs (memRead, memWrite, memType, execute result used as the address, regData2 used as store data) and performs the access on a word-wide req/ack data bus. It generates byte enables and store-lane replication, extracts and sign- or zero-extends load data, and stalls the pipeline until the access completes or times out.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: REQ-state cycles without bus_ack before the access is aborted with bus_err; range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM; wins when both mem_read and mem_write are high.
- mem_type  in  3  funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 decode as word.
- addr  in  32  byte address (execute result).
- store_data  in  32  store source (regData2).
- stall  out  1  combinational; holds IF..EX/MEM while an access is outstanding.
- load_data  out  32  formatted load result, valid while load_valid is high.
- load_valid  out  1  one-cycle pulse in DONE for a completed load.
- bus_err  out  1  one-cycle pulse in DONE when the access timed out.
- misalign  out  1  one-cycle pulse in DONE for a misaligned access (MEM_MISALIGN_TRAP_EN only).
- bus_req  out  1  registered bus request.
- bus_we  out  1  registered write strobe.
- bus_addr  out  32  registered word address, {addr[31:2],2'b00}.
- bus_be  out  4  registered byte enables.
- bus_wdata  out  32  registered lane-replicated store data.
- bus_ack  in  1  bus completion; accepted only while bus_req is high.
- bus_rdata  in  32  read data, sampled on the bus_ack cycle.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: an access is access = mem_read | mem_write. On an access, latch the decoded fields, drive bus_req=1 next cycle, and go to REQ. With a trapped misalignment, go directly to DONE with misalign set and no bus cycle.
- REQ: hold all bus outputs stable and count cycles. On bus_ack: capture bus_rdata, drop bus_req next cycle, and go to DONE. When the counter reaches TIMEOUT_CYCLES without an ack: drop bus_req, set bus_err, set load_data=0, and go to DONE.
- DONE: stall=0; load_valid, bus_err and misalign are valid for this cycle only; go to IDLE.
- stall = access & (state != DONE).
- Byte access: bus_be = 4'b0001 << addr[1:0]; bus_wdata = {4{store_data[7:0]}}.
- Half access: bus_be = addr[1] ? 4'b1100 : 4'b0011; bus_wdata = {2{store_data[15:0]}}.
- Word access: bus_be = 4'b1111; bus_wdata = store_data.
- Loads: select the lane from the latched addr[1:0]. Types 000/001 sign-extend; 100/101 zero-extend.
- Loads still drive bus_be for the accessed lanes, with bus_we=0.

## Timing
- Reset (asynchronous): state=IDLE, counter=0, and all outputs 0 (stall is 0 while no access is presented). bus_req falls immediately.
- Reset mid-REQ abandons the transaction. The bus must tolerate a dropped request.
- Minimum latency, with ack on the first REQ cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, ack.
  - cycle 2: DONE, stall=0.
  - Total: 2 stall cycles.
- Each extra wait cycle of the bus adds one stall cycle.
- Timeout: bus_err in DONE exactly TIMEOUT_CYCLES+1 cycles after REQ entry.
- bus_ack while bus_req=0 is ignored.
- Back-to-back accesses: the pipeline advances on the DONE cycle, and the next instruction is seen in IDLE on the following cycle. There is no bus bubble beyond the IDLE cycle.
- Inputs are sampled only in IDLE; changes during REQ are ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - The unit issues no bus cycle and spends one stall cycle (IDLE->DONE).
  - misalign pulses in DONE; load_data=0 and load_valid=0.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign is tied 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access proceeds normally.

## Test plan
- SW: addr=0x104, store_data=0xDEADBEEF, ack on the first REQ cycle -> bus_addr=0x104, be=1111, we=1, stall high 2 cycles.
- LB: addr=0x203, bus_rdata=0x80112233 -> load_data=0xFFFFFF80, load_valid 1 cycle. The same access as LBU -> 0x00000080.
- SH: addr=0x302, store_data=0x0000ABCD -> be=1100, wdata=0xABCDABCD. LHU at 0x302 with rdata=0xABCD1234 -> 0x0000ABCD.
- TIMEOUT_CYCLES=4, no ack -> bus_req drops, bus_err pulses and stall releases 5 cycles after REQ entry; load_data=0.
- LW at 0x101 with the macro defined -> no bus_req, misalign pulse, 1 stall cycle. Without the macro -> bus_addr=0x100, normal load.
- Reset asserted in REQ with a 3-cycle-late ack -> bus_req and stall fall asynchronously. After release, a fresh SB completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives a word-wide req/ack bus for loads and stores,
// formats load data and stalls the pipeline. Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lo_q, lo_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        access;
  logic        is_byte, is_half, is_word;
  logic        mis_dec;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  assign access  = mem_read | mem_write;
  assign is_byte = (mem_type[1:0] == 2'b00);
  assign is_half = (mem_type[1:0] == 2'b01);
  // 010, 011, 110 and 111 all land here
  assign is_word = mem_type[1];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_dec = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
  assign mis_dec = 1'b0;
`endif

  always_comb begin
    dec_be    = 4'b1111;
    dec_wdata = store_data;
    if (is_byte) begin
      dec_be    = 4'b0001 << addr[1:0];
      dec_wdata = {4{store_data[7:0]}};
    end else if (is_half) begin
      dec_be    = addr[1] ? 4'b1100 : 4'b0011;
      dec_wdata = {2{store_data[15:0]}};
    end
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    if (sz == 2'b00)
      fmt_load = {{24{b[7] & ~uns}}, b};
    else if (sz == 2'b01)
      fmt_load = {{16{h[15] & ~uns}}, h};
    else
      fmt_load = d;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lo_d        = lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      IDLE: begin
        load_data_d = 32'h0;
        if (access) begin
          we_d   = mem_write;
          size_d = mem_type[1:0];
          uns_d  = mem_type[2];
          lo_d   = addr[1:0];
          cnt_d  = 16'h0;
          if (mis_dec) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = dec_be;
            bus_wdata_d = dec_wdata;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ack && bus_req_q) begin
          load_data_d = we_q ? 32'h0 : fmt_load(bus_rdata, lo_q, size_q, uns_q);
          valid_d     = ~we_q;
          bus_req_d   = 1'b0;
          cnt_d       = 16'h0;
          state_d     = DONE;
        end else if (cnt_q == TIMEOUT_W) begin
          load_data_d = 32'h0;
          err_d       = 1'b1;
          bus_req_d   = 1'b0;
          cnt_d       = 16'h0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        load_data_d = 32'h0;
        bus_we_d    = 1'b0;
        bus_addr_d  = 32'h0;
        bus_be_d    = 4'h0;
        bus_wdata_d = 32'h0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 16'h0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lo_q        <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lo_q        <= lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
    end
  end

  // Gated by rst_n so the pipeline is released the instant reset asserts
  assign stall      = rst_n & access & (state_q != DONE);
  assign load_data  = load_data_q;
  assign load_valid = valid_q;
  assign bus_err    = err_q;
  assign misalign   = mis_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected bus requests and
// completions, a negedge monitor pops and compares them when the DUT presents them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .bus_err(bus_err), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        lv;
    logic        err;
    logic        mis;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int failures = 0;
  logic req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we,
                          input logic [31:0] wd);
    bus_exp_t e;
    e.addr = a; e.be = be; e.we = we; e.wdata = wd;
    bus_q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] d, input logic lv, input logic err, input logic mis);
    done_exp_t e;
    e.data = d; e.lv = lv; e.err = err; e.mis = mis;
    done_q.push_back(e);
  endtask

  // Monitor: a rising bus_req is a new bus request; any DONE pulse is a completion
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected: got request addr %h, expected none", bus_addr);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          check("bus_addr", bus_addr, e.addr);
          check("bus_be", {28'h0, bus_be}, {28'h0, e.be});
          check("bus_we", {31'h0, bus_we}, {31'h0, e.we});
          if (e.we) check("bus_wdata", bus_wdata, e.wdata);
          $display("bus req addr=%h be=%b we=%b wdata=%h", bus_addr, bus_be, bus_we, bus_wdata);
        end
      end
      if (load_valid || bus_err || misalign) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got lv=%b err=%b mis=%b, expected none",
                   load_valid, bus_err, misalign);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("load_data", load_data, d.data);
          check("load_valid", {31'h0, load_valid}, {31'h0, d.lv});
          check("bus_err", {31'h0, bus_err}, {31'h0, d.err});
          check("misalign", {31'h0, misalign}, {31'h0, d.mis});
          check("done_bus_req", {31'h0, bus_req}, 32'h0);
          $display("done data=%h lv=%b err=%b mis=%b", load_data, load_valid, bus_err, misalign);
        end
      end
    end
    req_prev <= bus_req;
  end

  // Present one access, act as the bus slave, count stall cycles until DONE
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] typ,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd_data,
                            input int ack_wait, input bit give_ack, input int exp_stalls,
                            input string name);
    int stalls;
    int req_cycles;
    bit done;
    stalls = 0; req_cycles = 0; done = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_type = typ; addr = a; store_data = sd; bus_ack = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      bus_ack = 1'b0;
      if (bus_req) begin
        if (give_ack && req_cycles == ack_wait) begin
          bus_ack = 1'b1;
          bus_rdata = rd_data;
        end
        req_cycles++;
      end
      if (!stall) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: stall never released, expected release", name);
    end
    check({name, "_stalls"}, stalls, exp_stalls);
    $display("access %s addr=%h stalls=%0d", name, a, stalls);
  endtask

  initial begin
    // Reset state, with an access presented to confirm stall is held low
    mem_read = 1'b1;
    #12;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_load_valid", {31'h0, load_valid}, 32'h0);
    check("rst_flags", {29'h0, bus_err, misalign, bus_we}, 32'h0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push_bus(32'h104, 4'b1111, 1'b1, 32'hDEADBEEF);
    run_access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1, 2, "sw");

    push_bus(32'h200, 4'b1000, 1'b0, 32'h0);
    push_done(32'hFFFFFF80, 1, 0, 0);
    run_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 1, 2, "lb");

    push_bus(32'h200, 4'b1000, 1'b0, 32'h0);
    push_done(32'h00000080, 1, 0, 0);
    run_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, 1, 2, "lbu");

    push_bus(32'h300, 4'b1100, 1'b1, 32'hABCDABCD);
    run_access(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 0, 1, 2, "sh");

    push_bus(32'h300, 4'b1100, 1'b0, 32'h0);
    push_done(32'h0000ABCD, 1, 0, 0);
    run_access(1, 0, 3'b101, 32'h302, 32'h0, 32'hABCD1234, 0, 1, 2, "lhu");

    push_bus(32'h300, 4'b0011, 1'b0, 32'h0);
    push_done(32'hFFFF8001, 1, 0, 0);
    run_access(1, 0, 3'b001, 32'h300, 32'h0, 32'h00008001, 0, 1, 2, "lh");

    push_bus(32'h208, 4'b1111, 1'b0, 32'h0);
    push_done(32'hCAFEF00D, 1, 0, 0);
    run_access(1, 0, 3'b010, 32'h208, 32'h0, 32'hCAFEF00D, 2, 1, 4, "lw_wait2");

    push_bus(32'h10C, 4'b1111, 1'b1, 32'h12345678);
    run_access(0, 1, 3'b011, 32'h10C, 32'h12345678, 32'h0, 0, 1, 2, "sw_t011");

    push_bus(32'h600, 4'b0010, 1'b1, 32'h77777777);
    run_access(1, 1, 3'b000, 32'h601, 32'h00000077, 32'h0, 0, 1, 2, "rdwr_sb");

    push_bus(32'h500, 4'b1111, 1'b0, 32'h0);
    push_done(32'h0, 0, 1, 0);
    run_access(1, 0, 3'b010, 32'h500, 32'h0, 32'h0, 0, 0, 6, "lw_timeout");

`ifdef MEM_MISALIGN_TRAP_EN
    push_done(32'h0, 0, 0, 1);
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 1, 1, "lw_mis");
`else
    push_bus(32'h100, 4'b1111, 1'b0, 32'h0);
    push_done(32'h11223344, 1, 0, 0);
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 1, 2, "lw_mis");
`endif

    push_bus(32'h200, 4'b0010, 1'b0, 32'h0);
    push_done(32'h000000A5, 1, 0, 0);
    run_access(1, 0, 3'b100, 32'h201, 32'h0, 32'h0000A500, 0, 1, 2, "lbu_l1");

    // Stray ack with no request outstanding must do nothing
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    check("stray_ack_stall", {31'h0, stall}, 32'h0);
    check("stray_ack_req", {31'h0, bus_req}, 32'h0);
    bus_ack = 1'b0;

    // Reset in the middle of REQ abandons the access
    @(posedge clk); #1;
    mem_read = 1'b1; mem_type = 3'b010; addr = 32'h700;
    push_bus(32'h700, 4'b1111, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_req_before", {31'h0, bus_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, bus_req}, 32'h0);
    check("mid_rst_stall", {31'h0, stall}, 32'h0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    bus_ack = 1'b0;
    rst_n = 1'b1;

    push_bus(32'h400, 4'b0010, 1'b1, 32'h5A5A5A5A);
    run_access(0, 1, 3'b000, 32'h401, 32'h0000005A, 32'h0, 0, 1, 2, "sb_after_rst");

    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (4) @(negedge clk);
    check("bus_q_empty", bus_q.size(), 32'h0);
    check("done_q_empty", done_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
